neuron_body: RTL and testbench
==============================

# neuron_body

Integrate-and-fire neuron body for one output of a layer. It consumes the per-synapse spike lines produced by the `spike_generation` stage and, once per gamma cycle, accumulates a weighted potential against the shared `time_val` counter. It records the cycle at which the potential first crosses threshold as the output spike time. Its outputs drive the next layer's `spike_generation` (`out_spike_time` → `spike_time`, `no_spike` → `should_spike`).

## Interface
- `NUM_INPUTS`, 8: number of synapse lines.
- `WEIGHT_WIDTH`, 3: unsigned weight width per synapse.
- `POT_WIDTH`, 10: unsigned potential and threshold width.

- `clk`  in  1: sole clock, rising edge.
- `rst_l`  in  1: reset; asynchronous, active-low.
- `start`  in  1: begin a gamma cycle; single-cycle pulse.
- `time_val`  in  `` `log_time_period``+1: shared gamma time counter.
- `spike_in`  in  `NUM_INPUTS`: spike lines from `spike_generation`; high means the synapse contributes this cycle.
- `weights`  in  `NUM_INPUTS*WEIGHT_WIDTH`: flattened weights; synapse i occupies bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; held stable during a gamma cycle.
- `threshold`  in  `POT_WIDTH`: firing threshold; held stable during a gamma cycle.
- `busy`  out  1: high while integrating.
- `done`  out  1: one-cycle pulse at end of gamma cycle.
- `no_spike`  out  1: 1 = no output spike recorded for the current or last cycle.
- `out_spike_time`  out  `` `log_time_period``: recorded spike time; all-ones when `no_spike`.
- `potential`  out  `POT_WIDTH`: current potential, exposed for debug.

## Operation
- FSM states:
  - IDLE: waits for `start`.
  - INTEGRATE: accumulates potential each cycle.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- IDLE → INTEGRATE on `start`.
  - Clears `potential` to 0.
  - Sets `no_spike`=1 and `out_spike_time` to all-ones.
- Each INTEGRATE cycle:
  - sum = Σ weight[i] over all i with `spike_in[i]`=1.
  - pot_next = `potential` + sum, saturating at 2^POT_WIDTH−1 (no wrap).
- Firing: if `no_spike`=1 and pot_next ≥ `threshold`:
  - `no_spike`←0 and `out_spike_time`←`time_val`[`` `log_time_period``−1:0] of that cycle.
  - First crossing only; later crossings are ignored. Integration continues.
- INTEGRATE → DONE on the cycle `time_val`[`` `log_time_period``]=1, i.e. the counter has reached the period.
  - That cycle does not integrate and cannot fire.
- `start` while in INTEGRATE or DONE restarts the cycle: same clearing as from IDLE, next state INTEGRATE.
- `threshold`=0: fires on the first INTEGRATE cycle, recording `time_val` of that cycle, even if sum=0.
- Saturated potential: stays at max; firing is unaffected.

## Timing
- Reset values (asynchronous on `rst_l`=0): state IDLE, `potential`=0, `busy`=0, `done`=0, `no_spike`=1, `out_spike_time`=all-ones.
- Reset mid-cycle discards all progress. After reset the block waits for a new `start`.
- All outputs are registered.
- `spike_in` is sampled at cycle t; `potential`, `no_spike` and `out_spike_time` reflect it at t+1.
- `busy` rises the cycle after `start` and falls the cycle `done` rises.
- `out_spike_time` and `no_spike` remain stable from DONE until the next `start`.

## Configuration
- `NEURON_LATERAL_INHIBIT_EN` defined:
  - Adds input port `inhibit_in` (1 bit), used for winner-take-all.
  - When sampled high in INTEGRATE, freezes `potential` and blocks firing for the rest of the gamma cycle.
  - A spike recorded before inhibit is kept.
  - The inhibit is cleared on `start`.
- Not defined: no port, no inhibit logic.

## Structure
- `neuron_pkg` holds:
  - the state enum `neuron_state_t` (IDLE, INTEGRATE, DONE);
  - the default width constants;
  - the saturating-add function.
- The timing width comes from `` `log_time_period`` in internal_defines.vh.
- One sub-module, `weight_sum`: combinational masked adder of `spike_in` × `weights`.
  - Output width is WEIGHT_WIDTH + $clog2(NUM_INPUTS+1).

## Test plan
- Reset: `rst_l` low mid-integration → outputs return to reset values immediately; no `done` pulse.
- Single firing: all weights=1; `spike_in`=8'h0F for all t; `threshold`=10; `start` at t=0 → potential 4, 8, 12; fires at `time_val`=2; `out_spike_time`=2, `no_spike`=0.
- No firing: `spike_in`=0, `threshold`=5 → `done` pulses after `time_val` MSB sets; `no_spike`=1; `out_spike_time`=all-ones.
- Saturation: all weights=7, all lines high, POT_WIDTH=6 → `potential` holds at 63 and never wraps; firing time is unchanged.
- Restart: `start` re-pulsed at `time_val`=3 → potential clears; the next spike time is measured from the new cycle.
- Inhibit (macro on): `inhibit_in` high at t=1 with `threshold`=10 and sum 4/cycle → no firing; `potential` stays 8.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types, default widths and the saturating adder for the neuron body.
// The gamma period width normally arrives from internal_defines.vh; a default is supplied here.
`ifndef LOG_TIME_PERIOD
`define LOG_TIME_PERIOD 3
`endif

package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INTEGRATE = 2'd1,
        DONE      = 2'd2
    } neuron_state_t;

    localparam int DEF_NUM_INPUTS   = 8;
    localparam int DEF_WEIGHT_WIDTH = 3;
    localparam int DEF_POT_WIDTH    = 10;
    localparam int TIME_WIDTH       = `LOG_TIME_PERIOD;

    // Computed one bit wider than the operands so the clamp never sees a wrapped sum.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] total;
        total = {1'b0, a} + {1'b0, b};
        if (total > {1'b0, max_val}) begin
            return max_val;
        end
        return total[31:0];
    endfunction

endpackage

// File: rtl/weight_sum.sv
// Combinational masked adder: sums the weights of every synapse whose spike line is high.
module weight_sum #(
    parameter int NUM_INPUTS   = 8,
    parameter int WEIGHT_WIDTH = 3,
    localparam int SUM_WIDTH   = WEIGHT_WIDTH + $clog2(NUM_INPUTS + 1)
) (
    input  logic [NUM_INPUTS-1:0]              spike_in,
    input  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0] weights,
    output logic [SUM_WIDTH-1:0]               sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (spike_in[i]) begin
                sum = sum + SUM_WIDTH'(weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
            end
        end
    end

endmodule

// File: rtl/neuron_body.sv
// Integrate-and-fire neuron body: records the first time_val at which the potential reaches threshold.
// Optional winner-take-all inhibit input is enabled by NEURON_LATERAL_INHIBIT_EN.
module neuron_body
    import neuron_pkg::*;
#(
    parameter int NUM_INPUTS   = DEF_NUM_INPUTS,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int POT_WIDTH    = DEF_POT_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_l,
    input  logic                              start,
    input  logic [TIME_WIDTH:0]               time_val,
    input  logic [NUM_INPUTS-1:0]             spike_in,
    input  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0] weights,
    input  logic [POT_WIDTH-1:0]              threshold,
`ifdef NEURON_LATERAL_INHIBIT_EN
    input  logic                              inhibit_in,
`endif
    output logic                              busy,
    output logic                              done,
    output logic                              no_spike,
    output logic [TIME_WIDTH-1:0]             out_spike_time,
    output logic [POT_WIDTH-1:0]              potential
);

    localparam int SUM_WIDTH = WEIGHT_WIDTH + $clog2(NUM_INPUTS + 1);
    localparam logic [POT_WIDTH-1:0] POT_MAX = '1;

    neuron_state_t         state;
    logic [SUM_WIDTH-1:0]  syn_sum;
    logic [POT_WIDTH-1:0]  pot_next;
    logic                  integrate_en;
    logic                  period_end;

    weight_sum #(
        .NUM_INPUTS  (NUM_INPUTS),
        .WEIGHT_WIDTH(WEIGHT_WIDTH)
    ) u_weight_sum (
        .spike_in(spike_in),
        .weights (weights),
        .sum     (syn_sum)
    );

    assign pot_next   = POT_WIDTH'(sat_add(32'(potential), 32'(syn_sum), 32'(POT_MAX)));
    assign period_end = time_val[TIME_WIDTH];

`ifdef NEURON_LATERAL_INHIBIT_EN
    // Inhibit is registered: the cycle that samples it still integrates, later cycles freeze.
    logic inhibited;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            inhibited <= 1'b0;
        end else if (start) begin
            inhibited <= 1'b0;
        end else if (state == INTEGRATE && !period_end && inhibit_in) begin
            inhibited <= 1'b1;
        end
    end

    assign integrate_en = !inhibited;
`else
    assign integrate_en = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state          <= IDLE;
            potential      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            no_spike       <= 1'b1;
            out_spike_time <= '1;
        end else begin
            done <= 1'b0;
            if (start) begin
                // A start in any state opens a fresh gamma cycle.
                state          <= INTEGRATE;
                potential      <= '0;
                busy           <= 1'b1;
                no_spike       <= 1'b1;
                out_spike_time <= '1;
            end else begin
                case (state)
                    INTEGRATE: begin
                        if (period_end) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (integrate_en) begin
                            potential <= pot_next;
                            if (no_spike && pot_next >= threshold) begin
                                no_spike       <= 1'b0;
                                out_spike_time <= time_val[TIME_WIDTH-1:0];
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_neuron_body.sv
// Self-checking bench for neuron_body: a full-width instance plus a 6-bit-potential instance for saturation.
// Exercises NEURON_LATERAL_INHIBIT_EN when that macro is defined.
module tb_neuron_body;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_l;
    logic        start;
    logic [3:0]  time_val;
    logic [7:0]  spike_in;
    logic [23:0] weights;
    logic [9:0]  threshold;
    logic [5:0]  threshold_s;
`ifdef NEURON_LATERAL_INHIBIT_EN
    logic        inhibit_in;
`endif

    logic        busy, done, no_spike;
    logic [2:0]  out_spike_time;
    logic [9:0]  potential;
    logic        busy_s, done_s, no_spike_s;
    logic [2:0]  out_spike_time_s;
    logic [5:0]  potential_s;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    neuron_body #(.NUM_INPUTS(8), .WEIGHT_WIDTH(3), .POT_WIDTH(10)) dut (
        .clk(clk), .rst_l(rst_l), .start(start), .time_val(time_val),
        .spike_in(spike_in), .weights(weights), .threshold(threshold),
`ifdef NEURON_LATERAL_INHIBIT_EN
        .inhibit_in(inhibit_in),
`endif
        .busy(busy), .done(done), .no_spike(no_spike),
        .out_spike_time(out_spike_time), .potential(potential)
    );

    neuron_body #(.NUM_INPUTS(8), .WEIGHT_WIDTH(3), .POT_WIDTH(6)) dut_s (
        .clk(clk), .rst_l(rst_l), .start(start), .time_val(time_val),
        .spike_in(spike_in), .weights(weights), .threshold(threshold_s),
`ifdef NEURON_LATERAL_INHIBIT_EN
        .inhibit_in(inhibit_in),
`endif
        .busy(busy_s), .done(done_s), .no_spike(no_spike_s),
        .out_spike_time(out_spike_time_s), .potential(potential_s)
    );

    function automatic int wsum(input logic [7:0] s, input logic [23:0] w);
        int acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (s[i]) acc += int'(w[i*3 +: 3]);
        end
        return acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One gamma cycle: start pulse, eight integrate slots, end-of-period slot, optional idle slots.
    task automatic run_gamma(input string name, input logic [7:0] pats [8],
                             input logic [3:0] start_tv, input bit linger);
        int pot = 0, pot_s = 0, ft = 7, ft_s = 7;
        bit fired = 0, fired_s = 0;
        logic [15:0] obs, expv;
        logic [11:0] obs_s, exp_s;
        logic [3:0]  got, want;
        start = 1'b1; time_val = start_tv; spike_in = 8'($urandom_range(0, 255));
        tick();
        start = 1'b0;
        checks++;
        obs  = {busy, done, no_spike, out_spike_time, potential};
        expv = {1'b1, 1'b0, 1'b1, 3'b111, 10'd0};
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s start_clear got %h want %h", name, obs, expv);
        end
        for (int t = 0; t < 8; t++) begin
            time_val = 4'(t); spike_in = pats[t];
            tick();
            pot   = (pot + wsum(pats[t], weights) > 1023) ? 1023 : pot + wsum(pats[t], weights);
            pot_s = (pot_s + wsum(pats[t], weights) > 63) ? 63 : pot_s + wsum(pats[t], weights);
            if (!fired && pot >= int'(threshold)) begin fired = 1; ft = t; end
            if (!fired_s && pot_s >= int'(threshold_s)) begin fired_s = 1; ft_s = t; end
            checks++;
            obs  = {busy, done, no_spike, out_spike_time, potential};
            expv = {1'b1, 1'b0, !fired, 3'(ft), 10'(pot)};
            if (obs !== expv) begin
                errors++;
                $display("FAIL %s integ t=%0d got %h want %h", name, t, obs, expv);
            end
            checks++;
            obs_s = {busy_s, done_s, no_spike_s, out_spike_time_s, potential_s};
            exp_s = {1'b1, 1'b0, !fired_s, 3'(ft_s), 6'(pot_s)};
            if (obs_s !== exp_s) begin
                errors++;
                $display("FAIL %s integ_small t=%0d got %h want %h", name, t, obs_s, exp_s);
            end
        end
        exp_q.push_back({!fired_s, 3'(ft_s)});
        time_val = 4'd8; spike_in = 8'hFF;
        tick();
        checks++;
        obs  = {busy, done, no_spike, out_spike_time, potential};
        expv = {1'b0, 1'b1, !fired, 3'(ft), 10'(pot)};
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s done_pulse got %h want %h", name, obs, expv);
        end
        checks++;
        got  = {no_spike_s, out_spike_time_s};
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
        if (got !== want || done_s !== 1'b1) begin
            errors++;
            $display("FAIL %s small_result got %h/%b want %h/1", name, got, done_s, want);
        end
        if (linger) begin
            for (int k = 0; k < 2; k++) begin
                time_val = 4'($urandom_range(0, 15)); spike_in = 8'($urandom_range(0, 255));
                tick();
                checks++;
                obs  = {busy, done, no_spike, out_spike_time, potential};
                expv = {1'b0, 1'b0, !fired, 3'(ft), 10'(pot)};
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL %s idle_hold k=%0d got %h want %h", name, k, obs, expv);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] obs, expv;
        rst_l = 1'b0; start = 1'b0; time_val = 4'd0; spike_in = 8'h00;
        weights = 24'o11111111; threshold = 10'd10; threshold_s = 6'd10;
        tick();
        checks++;
        obs  = {busy, done, no_spike, out_spike_time, potential};
        expv = {1'b0, 1'b0, 1'b1, 3'b111, 10'd0};
        if (obs !== expv) begin
            errors++;
            $display("FAIL reset_values got %h want %h", obs, expv);
        end
        rst_l = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        for (int t = 0; t < 3; t++) begin
            time_val = 4'(t); spike_in = 8'h0F; tick();
        end
        checks++;
        if (potential !== 10'd12 || no_spike !== 1'b0) begin
            errors++;
            $display("FAIL reset_pre pot got %0d/%b want 12/0", potential, no_spike);
        end
        rst_l = 1'b0;
        #1;
        checks++;
        obs  = {busy, done, no_spike, out_spike_time, potential};
        if (obs !== expv || potential_s !== 6'd0 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got %h want %h", obs, expv);
        end
        time_val = 4'd8;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done got %b%b want 00", done, busy);
            end
        end
        rst_l = 1'b1;
        for (int t = 0; t < 3; t++) begin
            time_val = 4'(t); spike_in = 8'hFF; tick();
        end
        checks++;
        obs = {busy, done, no_spike, out_spike_time, potential};
        if (obs !== expv) begin
            errors++;
            $display("FAIL reset_wait_start got %h want %h", obs, expv);
        end
    endtask

    task automatic test_single_fire();
        logic [7:0] p[8];
        weights = 24'o11111111; threshold = 10'd10; threshold_s = 6'd10;
        for (int i = 0; i < 8; i++) p[i] = 8'h0F;
        run_gamma("single_fire", p, 4'd0, 1'b1);
        checks++;
        if (out_spike_time !== 3'd2 || no_spike !== 1'b0) begin
            errors++;
            $display("FAIL single_fire_time got %0d/%b want 2/0", out_spike_time, no_spike);
        end
    endtask

    task automatic test_no_fire();
        logic [7:0] p[8];
        weights = 24'(($urandom_range(0, 65535) << 8) | $urandom_range(0, 255));
        threshold = 10'd5; threshold_s = 6'd5;
        for (int i = 0; i < 8; i++) p[i] = 8'h00;
        run_gamma("no_fire", p, 4'd0, 1'b1);
        checks++;
        if (out_spike_time !== 3'b111 || no_spike !== 1'b1) begin
            errors++;
            $display("FAIL no_fire_result got %0d/%b want 7/1", out_spike_time, no_spike);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] p[8];
        weights = 24'hFFFFFF; threshold = 10'd100; threshold_s = 6'd60;
        for (int i = 0; i < 8; i++) p[i] = 8'hFF;
        run_gamma("saturation", p, 4'd0, 1'b1);
        checks++;
        if (potential_s !== 6'd63 || out_spike_time_s !== 3'd1 || out_spike_time !== 3'd1) begin
            errors++;
            $display("FAIL saturation_hold got %0d t%0d/%0d want 63 t1/1",
                     potential_s, out_spike_time_s, out_spike_time);
        end
    endtask

    task automatic test_threshold_zero();
        logic [7:0] p[8];
        weights = 24'($urandom); threshold = 10'd0; threshold_s = 6'd0;
        for (int i = 0; i < 8; i++) p[i] = 8'h00;
        run_gamma("threshold_zero", p, 4'd0, 1'b1);
    endtask

    task automatic test_restart();
        logic [7:0] p[8];
        weights = 24'o11111111; threshold = 10'd10; threshold_s = 6'd10;
        start = 1'b1; time_val = 4'd0; tick(); start = 1'b0;
        for (int t = 0; t < 3; t++) begin
            time_val = 4'(t); spike_in = 8'h0F; tick();
        end
        checks++;
        if (potential !== 10'd12 || out_spike_time !== 3'd2 || no_spike !== 1'b0) begin
            errors++;
            $display("FAIL restart_first got %0d t%0d/%b want 12 t2/0", potential, out_spike_time, no_spike);
        end
        for (int i = 0; i < 8; i++) p[i] = 8'h03;
        run_gamma("restart", p, 4'd3, 1'b1);
        checks++;
        if (out_spike_time !== 3'd4) begin
            errors++;
            $display("FAIL restart_time got %0d want 4", out_spike_time);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] p[8];
        for (int g = 0; g < 3; g++) begin
            weights = 24'($urandom);
            threshold = 10'($urandom_range(0, 100)); threshold_s = 6'($urandom_range(0, 63));
            for (int i = 0; i < 8; i++) p[i] = 8'($urandom_range(0, 255));
            run_gamma("back_to_back", p, 4'd0, g == 2);
        end
    endtask

    task automatic test_random();
        logic [7:0] p[8];
        for (int g = 0; g < 12; g++) begin
            weights = 24'($urandom);
            threshold = 10'($urandom_range(0, 120)); threshold_s = 6'($urandom_range(0, 63));
            for (int i = 0; i < 8; i++) p[i] = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
            run_gamma("random", p, 4'($urandom_range(0, 7)), 1'b1);
        end
    endtask

`ifdef NEURON_LATERAL_INHIBIT_EN
    task automatic test_inhibit();
        int exp_pot;
        weights = 24'o11111111; threshold = 10'd10; threshold_s = 6'd10;
        start = 1'b1; time_val = 4'd0; inhibit_in = 1'b0; tick(); start = 1'b0;
        for (int t = 0; t < 8; t++) begin
            time_val = 4'(t); spike_in = 8'h0F; inhibit_in = (t == 1);
            tick();
            exp_pot = (t == 0) ? 4 : 8;
            checks++;
            if (potential !== 10'(exp_pot) || no_spike !== 1'b1) begin
                errors++;
                $display("FAIL inhibit t=%0d got %0d/%b want %0d/1", t, potential, no_spike, exp_pot);
            end
        end
        inhibit_in = 1'b0; time_val = 4'd8; tick();
        checks++;
        if (done !== 1'b1 || out_spike_time !== 3'b111) begin
            errors++;
            $display("FAIL inhibit_done got %b/%0d want 1/7", done, out_spike_time);
        end
        tick();
    endtask
`endif

    initial begin
`ifdef NEURON_LATERAL_INHIBIT_EN
        inhibit_in = 1'b0;
`endif
        test_reset();
        test_single_fire();
        test_no_fire();
        test_saturation();
        test_threshold_zero();
        test_restart();
        test_back_to_back();
        test_random();
`ifdef NEURON_LATERAL_INHIBIT_EN
        test_inhibit();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
